// File: rtl/n64adv_vinfo_pkg.sv
// Shared constants for the N64 video-info path: sync nibble bit positions,
// vinfo word bit positions and the default PAL line threshold.
package n64adv_vinfo_pkg;

    localparam int SY_VSYNC = 3;
    localparam int SY_CLAMP = 2;
    localparam int SY_HSYNC = 1;
    localparam int SY_CSYNC = 0;

    localparam int VI_PAL   = 1;
    localparam int VI_480I  = 0;

    localparam int LCNT_W_DEF     = 10;
    localparam int PAL_THRESH_DEF = 288;

endpackage

// File: rtl/n64_vinfo_detect.sv
// Infers {palmode, n64_480i} from the N64 sync nibble stream: lines per field
// select PAL/NTSC, the vsync phase relative to hsync across fields selects 480i.
module n64_vinfo_detect
    import n64adv_vinfo_pkg::*;
#(
    parameter int LCNT_W     = LCNT_W_DEF,
    parameter int PAL_THRESH = PAL_THRESH_DEF
) (
    input  logic       VCLK,
    input  logic       RST,
    input  logic       nVDSYNC,
    input  logic [3:0] Sync_pre,
    input  logic [3:0] Sync_cur,
    output logic [1:0] vinfo_o
);

    logic [LCNT_W-1:0] line_cnt;
    logic [LCNT_W-1:0] cnt_eval;
    logic              negedge_v;
    logic              negedge_h;
    logic              field_pal;
    logic              pal_vote;
    logic              palmode;
    logic              n64_480i;
    logic              last_fid;
    logic              fid_valid;
    logic              unused_sync;

    assign negedge_v = Sync_pre[SY_VSYNC] & ~Sync_cur[SY_VSYNC];
    assign negedge_h = Sync_pre[SY_HSYNC] & ~Sync_cur[SY_HSYNC];

    assign unused_sync = ^{Sync_pre[SY_CLAMP], Sync_pre[SY_CSYNC],
                           Sync_cur[SY_CLAMP], Sync_cur[SY_CSYNC]};

    // An hsync fall coincident with vsync still belongs to the ending field.
    always_comb begin
        cnt_eval = line_cnt;
        if (negedge_h && (line_cnt != '1))
            cnt_eval = line_cnt + 1'b1;
        field_pal = (int'(cnt_eval) > PAL_THRESH);
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            line_cnt  <= '0;
            pal_vote  <= 1'b0;
            palmode   <= 1'b0;
            n64_480i  <= 1'b0;
            last_fid  <= 1'b0;
            fid_valid <= 1'b0;
        end else if (!nVDSYNC) begin
            if (negedge_v) begin
                line_cnt <= '0;
                if (field_pal == pal_vote)
                    palmode <= field_pal;
                pal_vote <= field_pal;
                if (fid_valid)
                    n64_480i <= (negedge_h != last_fid);
                last_fid  <= negedge_h;
                fid_valid <= 1'b1;
            end else begin
                line_cnt <= cnt_eval;
            end
        end
    end

    always_comb begin
        vinfo_o          = '0;
        vinfo_o[VI_PAL]  = palmode;
        vinfo_o[VI_480I] = n64_480i;
    end

endmodule

// File: tb/tb_n64_vinfo_detect.sv
// Self-checking bench for n64_vinfo_detect: expected vinfo words are queued as
// each field is driven and compared right after the qualifying vsync edge.
module tb_n64_vinfo_detect;

    logic       VCLK = 1'b0;
    logic       RST = 1'b1;
    logic       nVDSYNC = 1'b1;
    logic [3:0] Sync_pre = 4'hF;
    logic [3:0] Sync_cur = 4'hF;
    logic [1:0] vinfo_o;

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;

    n64_vinfo_detect #(.LCNT_W(10), .PAL_THRESH(288)) dut (
        .VCLK     (VCLK),
        .RST      (RST),
        .nVDSYNC  (nVDSYNC),
        .Sync_pre (Sync_pre),
        .Sync_cur (Sync_cur),
        .vinfo_o  (vinfo_o)
    );

    always #5 VCLK = ~VCLK;

    // Scoreboard monitor: every qualified vsync fall outside reset yields a decision.
    always @(posedge VCLK) begin
        if (RST === 1'b0 && nVDSYNC === 1'b0 && Sync_pre[3] === 1'b1 && Sync_cur[3] === 1'b0) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL vsync_unexpected got=%b (no expected value queued)", vinfo_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (vinfo_o !== mon_exp) begin
                    failures++;
                    $display("FAIL vsync_decision got=%b exp=%b t=%0t", vinfo_o, mon_exp, $time);
                end
            end
        end
    end

    task automatic drive(input logic q, input logic vs, input logic hs, input logic rst);
        RST         = rst;
        nVDSYNC     = ~q;
        Sync_pre    = 4'hF;
        Sync_cur    = 4'hF;
        Sync_cur[3] = ~vs;
        Sync_cur[1] = ~hs;
        @(posedge VCLK);
        #1;
    endtask

    task automatic lines(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    // A field of n lines: n hsync falls counted before the vsync decision.
    task automatic field(input int n, input bit coincident, input logic [1:0] exp);
        if (coincident) begin
            lines(n - 1);
            exp_q.push_back(exp);
            drive(1'b1, 1'b1, 1'b1, 1'b0);
        end else begin
            lines(n);
            exp_q.push_back(exp);
            drive(1'b1, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain_check(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pending got=%0d exp=0 decisions outstanding", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i[0], 1'b1, 1'b1);
            checks++;
            if (vinfo_o !== 2'b00) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=00", i, vinfo_o);
            end
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (vinfo_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_release got=%b exp=00", vinfo_o);
        end
    endtask

    task automatic test_ntsc_prog();
        do_reset();
        for (int i = 0; i < 4; i++) field(263, 1'b1, 2'b00);
        drain_check("ntsc_prog");
    endtask

    task automatic test_pal_prog();
        do_reset();
        field(313, 1'b1, 2'b00);
        field(313, 1'b1, 2'b10);
        field(313, 1'b1, 2'b10);
        field(263, 1'b1, 2'b10);
        field(313, 1'b1, 2'b10);
        drain_check("pal_prog");
    endtask

    task automatic test_ntsc_interlaced();
        do_reset();
        field(263, 1'b1, 2'b00);
        field(262, 1'b0, 2'b01);
        field(263, 1'b1, 2'b01);
        field(262, 1'b0, 2'b01);
        field(262, 1'b0, 2'b00);
        field(262, 1'b0, 2'b00);
        drain_check("ntsc_480i");
    endtask

    task automatic test_qualification();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            lines(100);
            repeat (300) drive(1'b0, 1'b0, 1'b1, 1'b0);
            repeat (5) drive(1'b0, 1'b1, 1'b1, 1'b0);
            checks++;
            if (dut.line_cnt !== 10'd100) begin
                failures++;
                $display("FAIL qual_hold fld=%0d got=%0d exp=100", f, dut.line_cnt);
            end
            lines(187);
            exp_q.push_back(2'b00);
            drive(1'b1, 1'b1, 1'b1, 1'b0);
        end
        field(289, 1'b1, 2'b00);
        field(289, 1'b1, 2'b10);
        field(288, 1'b1, 2'b10);
        drain_check("qual_thresh");
    endtask

    task automatic test_saturation();
        do_reset();
        field(263, 1'b1, 2'b00);
        field(263, 1'b1, 2'b00);
        lines(1500);
        checks++;
        if (dut.line_cnt !== 10'd1023) begin
            failures++;
            $display("FAIL sat_count got=%0d exp=1023", dut.line_cnt);
        end
        checks++;
        if (vinfo_o !== 2'b00) begin
            failures++;
            $display("FAIL sat_hold got=%b exp=00", vinfo_o);
        end
        field(1, 1'b1, 2'b00);
        field(1500, 1'b1, 2'b10);
        drain_check("saturation");
    endtask

    task automatic test_reset_mid();
        do_reset();
        field(313, 1'b1, 2'b00);
        field(313, 1'b0, 2'b11);
        field(313, 1'b1, 2'b11);
        lines(100);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (vinfo_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=00", vinfo_o);
        end
        field(313, 1'b1, 2'b00);
        field(313, 1'b0, 2'b11);
        drain_check("reset_mid");
    endtask

    initial begin
        test_reset();
        test_ntsc_prog();
        test_pal_prog();
        test_ntsc_interlaced();
        test_qualification();
        test_saturation();
        test_reset_mid();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
